// File: rtl/mci_mcu_trace_qualifier.sv
// Trace qualifier in front of the MCU trace buffer: arms on a trigger address,
// filters retired-instruction packets, stops after a post-trigger count, and
// re-registers forwarded packets with a single-cycle valid strobe.
// Ports:
//   clk, rst                      clock, async active-high reset
//   debug_en, cfg_*               unlock, capture control and filter config
//   mcu_trace_rv_i_*_ip           core trace port
//   trace_o_*                     registered forwarded packet to the buffer
//   qual_state, post_cnt_remaining, fwd_cnt, drop_cnt   status readback
module mci_mcu_trace_qualifier #(
  parameter int unsigned POST_CNT_WIDTH = 16,
  parameter int unsigned FWD_CNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      debug_en,
  input  logic                      cfg_en,
  input  logic                      cfg_clear,
  input  logic [1:0]                cfg_mode,
  input  logic                      cfg_start_on_trigger,
  input  logic [31:0]               cfg_trig_addr,
  input  logic [31:0]               cfg_addr_lo,
  input  logic [31:0]               cfg_addr_hi,
  input  logic [POST_CNT_WIDTH-1:0] cfg_post_trig_cnt,
  input  logic [31:0]               mcu_trace_rv_i_insn_ip,
  input  logic [31:0]               mcu_trace_rv_i_address_ip,
  input  logic                      mcu_trace_rv_i_valid_ip,
  input  logic                      mcu_trace_rv_i_exception_ip,
  input  logic [4:0]                mcu_trace_rv_i_ecause_ip,
  input  logic                      mcu_trace_rv_i_interrupt_ip,
  input  logic [31:0]               mcu_trace_rv_i_tval_ip,
  output logic [31:0]               trace_o_insn,
  output logic [31:0]               trace_o_address,
  output logic                      trace_o_valid,
  output logic                      trace_o_exception,
  output logic [4:0]                trace_o_ecause,
  output logic                      trace_o_interrupt,
  output logic [31:0]               trace_o_tval,
  output logic [1:0]                qual_state,
  output logic [POST_CNT_WIDTH-1:0] post_cnt_remaining,
  output logic [FWD_CNT_WIDTH-1:0]  fwd_cnt,
  output logic [15:0]               drop_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0] state, state_nxt;
  logic       go_c;
  logic       in_win_c;
  logic       pass_c;
  logic       trig_hit_c;
  logic       fwd_c;
  logic       drop_c;

  // Empty window (lo > hi) falls out naturally: no address satisfies both bounds.
  assign go_c       = cfg_en & debug_en;
  assign in_win_c   = (mcu_trace_rv_i_address_ip >= cfg_addr_lo) &&
                      (mcu_trace_rv_i_address_ip <= cfg_addr_hi);
  assign trig_hit_c = (state == S_ARMED) && mcu_trace_rv_i_valid_ip &&
                      (mcu_trace_rv_i_address_ip == cfg_trig_addr);

  // Filter decision, only consulted in CAPTURE.
  always_comb begin
    pass_c = 1'b0;
    case (cfg_mode)
      2'd0:    pass_c = 1'b1;
      2'd1:    pass_c = mcu_trace_rv_i_exception_ip | mcu_trace_rv_i_interrupt_ip;
      2'd2:    pass_c = in_win_c;
      default: pass_c = ~in_win_c;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: clear and loss of go dominate normal transitions.
  always_comb begin
    state_nxt = state;
    if (cfg_clear || !go_c) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = cfg_start_on_trigger ? S_ARMED : S_CAPTURE;
        S_ARMED:   if (trig_hit_c)
                     state_nxt = (cfg_post_trig_cnt == POST_CNT_WIDTH'(1)) ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (fwd_c && post_cnt_remaining == POST_CNT_WIDTH'(1))
                     state_nxt = S_DONE;
        default:   state_nxt = S_DONE;
      endcase
    end
  end

  // Forward/drop decisions for the current input packet.
  always_comb begin
    fwd_c  = 1'b0;
    drop_c = 1'b0;
    if (!cfg_clear && go_c) begin
      case (state)
        S_ARMED:   fwd_c = trig_hit_c;
        S_CAPTURE: begin
          fwd_c  = mcu_trace_rv_i_valid_ip & pass_c;
          drop_c = mcu_trace_rv_i_valid_ip & ~pass_c;
        end
        default: ;
      endcase
    end
  end

  // Counters and post-trigger budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_cnt_remaining <= '0;
      fwd_cnt            <= '0;
      drop_cnt           <= '0;
    end else if (cfg_clear) begin
      post_cnt_remaining <= '0;
      fwd_cnt            <= '0;
      drop_cnt           <= '0;
    end else if (!go_c) begin
      // Returning to IDLE: the budget is meaningless there, fwd/drop hold.
      post_cnt_remaining <= '0;
    end else begin
      if (fwd_c && fwd_cnt != '1)
        fwd_cnt <= fwd_cnt + FWD_CNT_WIDTH'(1);
      if (drop_c && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
      if (state == S_IDLE && !cfg_start_on_trigger)
        post_cnt_remaining <= cfg_post_trig_cnt;
      else if (trig_hit_c)
        // The trigger packet itself consumes one unit of a nonzero budget.
        post_cnt_remaining <= (cfg_post_trig_cnt == '0) ? '0
                              : cfg_post_trig_cnt - POST_CNT_WIDTH'(1);
      else if (state == S_CAPTURE && fwd_c && post_cnt_remaining != '0)
        post_cnt_remaining <= post_cnt_remaining - POST_CNT_WIDTH'(1);
    end
  end

  // Output pipeline: fields hold between strobes, valid pulses per packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_o_insn      <= '0;
      trace_o_address   <= '0;
      trace_o_valid     <= 1'b0;
      trace_o_exception <= 1'b0;
      trace_o_ecause    <= '0;
      trace_o_interrupt <= 1'b0;
      trace_o_tval      <= '0;
    end else begin
      trace_o_valid <= fwd_c;
      if (fwd_c) begin
        trace_o_insn      <= mcu_trace_rv_i_insn_ip;
        trace_o_address   <= mcu_trace_rv_i_address_ip;
        trace_o_exception <= mcu_trace_rv_i_exception_ip;
        trace_o_ecause    <= mcu_trace_rv_i_ecause_ip;
        trace_o_interrupt <= mcu_trace_rv_i_interrupt_ip;
        trace_o_tval      <= mcu_trace_rv_i_tval_ip;
      end
    end
  end

  assign qual_state = state;

endmodule

// File: tb/tb_mci_mcu_trace_qualifier.sv
// Directed testbench for mci_mcu_trace_qualifier.
module tb_mci_mcu_trace_qualifier;

  logic        clk, rst, debug_en, cfg_en, cfg_clear, cfg_start_on_trigger;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_trig_addr, cfg_addr_lo, cfg_addr_hi;
  logic [15:0] cfg_post_trig_cnt;
  logic [31:0] in_insn, in_addr, in_tval;
  logic        in_valid, in_exc, in_int;
  logic [4:0]  in_ecause;
  logic [31:0] trace_o_insn, trace_o_address, trace_o_tval;
  logic        trace_o_valid, trace_o_exception, trace_o_interrupt;
  logic [4:0]  trace_o_ecause;
  logic [1:0]  qual_state;
  logic [15:0] post_cnt_remaining;
  logic [31:0] fwd_cnt;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  mci_mcu_trace_qualifier dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .cfg_en(cfg_en), .cfg_clear(cfg_clear),
    .cfg_mode(cfg_mode), .cfg_start_on_trigger(cfg_start_on_trigger),
    .cfg_trig_addr(cfg_trig_addr), .cfg_addr_lo(cfg_addr_lo), .cfg_addr_hi(cfg_addr_hi),
    .cfg_post_trig_cnt(cfg_post_trig_cnt),
    .mcu_trace_rv_i_insn_ip(in_insn), .mcu_trace_rv_i_address_ip(in_addr),
    .mcu_trace_rv_i_valid_ip(in_valid), .mcu_trace_rv_i_exception_ip(in_exc),
    .mcu_trace_rv_i_ecause_ip(in_ecause), .mcu_trace_rv_i_interrupt_ip(in_int),
    .mcu_trace_rv_i_tval_ip(in_tval),
    .trace_o_insn(trace_o_insn), .trace_o_address(trace_o_address),
    .trace_o_valid(trace_o_valid), .trace_o_exception(trace_o_exception),
    .trace_o_ecause(trace_o_ecause), .trace_o_interrupt(trace_o_interrupt),
    .trace_o_tval(trace_o_tval), .qual_state(qual_state),
    .post_cnt_remaining(post_cnt_remaining), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [31:0] a, input logic exc, input logic intr);
    in_valid  = 1'b1;
    in_addr   = a;
    in_insn   = ~a;
    in_tval   = a + 32'd1;
    in_ecause = a[6:2];
    in_exc    = exc;
    in_int    = intr;
  endtask

  task automatic no_pkt();
    in_valid = 1'b0;
    in_exc   = 1'b0;
    in_int   = 1'b0;
  endtask

  // Send one packet and check the strobe (and address when forwarded).
  task automatic send_chk(input string tag, input logic [31:0] a, input logic exp_fwd);
    pkt(a, 1'b0, 1'b0);
    step();
    chk({tag, ".valid"}, 32'(trace_o_valid), 32'(exp_fwd));
    if (exp_fwd) chk({tag, ".addr"}, trace_o_address, a);
  endtask

  // One-cycle clear pulse; leaves cfg_clear low afterwards.
  task automatic clear_pulse();
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
  endtask

  logic [31:0] win_addr [4];
  logic [15:0] rem_exp  [6];

  initial begin
    win_addr = '{32'h1FFC, 32'h2000, 32'h20FF, 32'h2100};
    rem_exp  = '{16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    rst = 1'b1; debug_en = 1'b1; cfg_en = 1'b0; cfg_clear = 1'b0;
    cfg_mode = 2'd0; cfg_start_on_trigger = 1'b0; cfg_trig_addr = 32'h0;
    cfg_addr_lo = 32'h0; cfg_addr_hi = 32'h0; cfg_post_trig_cnt = 16'd0;
    in_insn = 32'h0; in_addr = 32'h0; in_tval = 32'h0; in_ecause = 5'd0;
    no_pkt();
    #3;
    chk("rst.state", 32'(qual_state), 32'd0);
    chk("rst.valid", 32'(trace_o_valid), 32'd0);
    chk("rst.fwd",   fwd_cnt, 32'd0);
    chk("rst.addr",  trace_o_address, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle.hold", 32'(qual_state), 32'd0);

    // Mode 0, immediate capture, unlimited.
    cfg_en = 1'b1;
    step();
    chk("t1.state", 32'(qual_state), 32'd2);
    chk("t1.noleave_fwd", 32'(trace_o_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      pkt(32'h100 + 32'(i) * 4, 1'b0, 1'b0);
      step();
      chk("t1.valid", 32'(trace_o_valid), 32'd1);
      chk("t1.addr",  trace_o_address, 32'h100 + 32'(i) * 4);
      chk("t1.insn",  trace_o_insn, ~(32'h100 + 32'(i) * 4));
      chk("t1.tval",  trace_o_tval, 32'h101 + 32'(i) * 4);
    end
    no_pkt();
    step();
    chk("t1.idle_valid", 32'(trace_o_valid), 32'd0);
    chk("t1.hold_addr", trace_o_address, 32'h110);
    chk("t1.fwd",  fwd_cnt, 32'd5);
    chk("t1.drop", 32'(drop_cnt), 32'd0);
    chk("t1.state_end", 32'(qual_state), 32'd2);

    // Trigger arming.
    cfg_start_on_trigger = 1'b1;
    cfg_trig_addr = 32'h1000;
    clear_pulse();
    chk("t2.clr_state", 32'(qual_state), 32'd0);
    chk("t2.clr_fwd", fwd_cnt, 32'd0);
    step();
    chk("t2.armed", 32'(qual_state), 32'd1);
    send_chk("t2.pre", 32'h0FF0, 1'b0);
    chk("t2.pre_fwd", fwd_cnt, 32'd0);
    chk("t2.pre_drop", 32'(drop_cnt), 32'd0);
    chk("t2.pre_state", 32'(qual_state), 32'd1);
    send_chk("t2.trig", 32'h1000, 1'b1);
    chk("t2.trig_state", 32'(qual_state), 32'd2);
    send_chk("t2.post", 32'h1004, 1'b1);
    chk("t2.fwd", fwd_cnt, 32'd2);

    // Address window, inside then outside.
    no_pkt();
    cfg_start_on_trigger = 1'b0;
    cfg_mode = 2'd2; cfg_addr_lo = 32'h2000; cfg_addr_hi = 32'h20FF;
    clear_pulse();
    step();
    chk("t3.state", 32'(qual_state), 32'd2);
    for (int i = 0; i < 4; i++)
      send_chk("t3.m2", win_addr[i], (i == 1 || i == 2));
    chk("t3.m2_fwd", fwd_cnt, 32'd2);
    chk("t3.m2_drop", 32'(drop_cnt), 32'd2);
    cfg_mode = 2'd3;
    for (int i = 0; i < 4; i++)
      send_chk("t3.m3", win_addr[i], (i == 0 || i == 3));
    chk("t3.m3_fwd", fwd_cnt, 32'd4);
    chk("t3.m3_drop", 32'(drop_cnt), 32'd4);
    // Empty window: mode 2 rejects, mode 3 accepts.
    cfg_addr_lo = 32'h3000; cfg_addr_hi = 32'h2000;
    cfg_mode = 2'd2;
    send_chk("t3.empty_m2", 32'h2800, 1'b0);
    cfg_mode = 2'd3;
    send_chk("t3.empty_m3", 32'h2800, 1'b1);
    // Exception/interrupt filter.
    cfg_mode = 2'd1;
    pkt(32'h4000, 1'b1, 1'b0);
    step();
    chk("t3.m1_exc", 32'(trace_o_valid), 32'd1);
    chk("t3.m1_exc_flag", 32'(trace_o_exception), 32'd1);
    pkt(32'h4004, 1'b0, 1'b1);
    step();
    chk("t3.m1_int", 32'(trace_o_interrupt), 32'd1);
    send_chk("t3.m1_plain", 32'h4008, 1'b0);
    chk("t3.drop_total", 32'(drop_cnt), 32'd6);

    // Post-trigger count of 3.
    no_pkt();
    cfg_mode = 2'd0;
    cfg_post_trig_cnt = 16'd3;
    clear_pulse();
    step();
    chk("t4.rem_load", 32'(post_cnt_remaining), 32'd3);
    for (int i = 0; i < 6; i++) begin
      send_chk("t4.pkt", 32'h5000 + 32'(i) * 4, (i < 3));
      chk("t4.rem", 32'(post_cnt_remaining), 32'(rem_exp[i]));
      if (i >= 2) chk("t4.done", 32'(qual_state), 32'd3);
    end
    chk("t4.fwd", fwd_cnt, 32'd3);
    no_pkt();
    clear_pulse();
    chk("t4.clr_state", 32'(qual_state), 32'd0);
    chk("t4.clr_fwd", fwd_cnt, 32'd0);
    chk("t4.clr_drop", 32'(drop_cnt), 32'd0);
    chk("t4.clr_rem", 32'(post_cnt_remaining), 32'd0);

    // debug_en drop mid-capture.
    cfg_post_trig_cnt = 16'd0;
    step();
    chk("t5.state", 32'(qual_state), 32'd2);
    send_chk("t5.a", 32'h6000, 1'b1);
    send_chk("t5.b", 32'h6004, 1'b1);
    debug_en = 1'b0;
    send_chk("t5.gated", 32'h6008, 1'b0);
    chk("t5.idle", 32'(qual_state), 32'd0);
    chk("t5.fwd_hold", fwd_cnt, 32'd2);
    debug_en = 1'b1;
    no_pkt();
    step();
    chk("t5.restart", 32'(qual_state), 32'd2);
    send_chk("t5.c", 32'h600C, 1'b1);
    chk("t5.fwd", fwd_cnt, 32'd3);

    // Asynchronous reset mid-packet.
    pkt(32'h7000, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.valid", 32'(trace_o_valid), 32'd0);
    chk("t6.state", 32'(qual_state), 32'd0);
    chk("t6.fwd",   fwd_cnt, 32'd0);
    chk("t6.addr",  trace_o_address, 32'd0);
    step();
    cfg_en = 1'b0;
    rst = 1'b0;
    step();
    chk("t6.post_valid", 32'(trace_o_valid), 32'd0);
    chk("t6.post_state", 32'(qual_state), 32'd0);
    step();
    chk("t6.still_idle", 32'(trace_o_valid), 32'd0);
    cfg_en = 1'b1;
    no_pkt();
    step();
    chk("t6.reen", 32'(qual_state), 32'd2);
    send_chk("t6.pkt", 32'h7004, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mci_mcu_trace_qualifier.md
Name: mci_mcu_trace_qualifier

Overview:
- Sits directly upstream of the MCU trace buffer, between the MCU core trace port and the buffer's trace inputs.
- Decides which retired-instruction trace packets are forwarded for storage: address-trigger arming, a filter mode, and a post-trigger stop count.
- Forwarded packets are re-registered (1-cycle pipeline) and presented on the same signal set the buffer consumes, with a single valid strobe.
- Per-capture counters and a state readback are exported for CSR/DMI status.

Parameters:
- POST_CNT_WIDTH, 16, width of the post-trigger packet count and the remaining-count output.
- FWD_CNT_WIDTH, 32, width of the saturating forwarded-packet counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- debug_en  in  1  debug unlock; 0 forces IDLE and blocks all forwarding.
- cfg_en  in  1  capture enable (level).
- cfg_clear  in  1  one-cycle pulse: abort/re-arm, return to IDLE, clear counters.
- cfg_mode  in  2  filter: 0 all, 1 exception|interrupt only, 2 inside address window, 3 outside window.
- cfg_start_on_trigger  in  1  1: wait in ARMED for trigger address; 0: capture immediately.
- cfg_trig_addr  in  32  trigger instruction address.
- cfg_addr_lo, cfg_addr_hi  in  32 each  inclusive unsigned window bounds.
- cfg_post_trig_cnt  in  POST_CNT_WIDTH  packets to forward before stopping; 0 means unlimited.
- mcu_trace_rv_i_insn_ip, _address_ip, _tval_ip  in  32 each  core trace fields.
- mcu_trace_rv_i_valid_ip, _exception_ip, _interrupt_ip  in  1 each  core trace qualifiers.
- mcu_trace_rv_i_ecause_ip  in  5  exception cause.
- trace_o_insn, trace_o_address, trace_o_tval  out  32 each  registered forwarded fields.
- trace_o_valid, trace_o_exception, trace_o_interrupt  out  1 each  registered; valid is a 1-cycle strobe per packet.
- trace_o_ecause  out  5  registered forwarded cause.
- qual_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- post_cnt_remaining  out  POST_CNT_WIDTH  packets left before DONE (0 when unlimited or idle).
- fwd_cnt  out  FWD_CNT_WIDTH  saturating count of packets forwarded since last clear.
- drop_cnt  out  16  saturating count of valid packets rejected by the filter while in CAPTURE.

Behaviour:
- Reset: state IDLE; every output is 0.
- go = cfg_en & debug_en. Priority order: rst > cfg_clear > !go > FSM transitions.
- cfg_clear: next state IDLE; fwd_cnt, drop_cnt and post_cnt_remaining cleared; no forward that cycle.
- !go in any state: next state IDLE; forwarding gated combinationally, so no trace_o_valid from that cycle's input. Counters hold.
- IDLE with go:
  - cfg_start_on_trigger=1: go to ARMED.
  - cfg_start_on_trigger=0: go to CAPTURE, loading post_cnt_remaining = cfg_post_trig_cnt.
  - No packet is forwarded in the cycle IDLE is left.
- ARMED: a valid packet with address == cfg_trig_addr moves the FSM to CAPTURE and loads post_cnt_remaining = cfg_post_trig_cnt.
  - The trigger packet is forwarded unconditionally, bypassing the filter.
  - It counts toward fwd_cnt and consumes one post count when the limit is nonzero.
  - Non-trigger packets in ARMED are neither forwarded nor counted.
- Filter pass (CAPTURE only):
  - mode0: always.
  - mode1: exception | interrupt.
  - mode2: lo <= address <= hi.
  - mode3: not mode2.
  - If lo > hi, the window is empty: mode2 never passes, mode3 always passes.
- CAPTURE, valid packet:
  - Pass: forward the packet and increment fwd_cnt.
  - Fail: increment drop_cnt; no forward.
  - When the limit is nonzero, each forward decrements post_cnt_remaining. Forwarding with post_cnt_remaining == 1 moves the FSM to DONE next cycle; that packet is still forwarded.
  - cfg_post_trig_cnt == 0: stays in CAPTURE indefinitely; post_cnt_remaining stays 0.
- DONE: nothing forwarded. Exits only via cfg_clear or !go, both to IDLE; re-arm needs go again.
- Config inputs are sampled live; changing them mid-capture affects the next packet.
- Output pipeline:
  - A forwarded packet registers every field on the next clk edge with trace_o_valid=1 for exactly one cycle.
  - Non-forward cycles drive trace_o_valid=0; other trace_o fields hold their last value.
  - Back-to-back valid inputs give back-to-back strobes; no stall, no backpressure.
- Counters saturate at all-ones and never wrap.

Test Plan:
- mode0, start_on_trigger=0, post=0, cfg_en up, 5 consecutive valid packets -> 5 strobes each 1 cycle after input with matching fields; fwd_cnt=5, drop_cnt=0, state CAPTURE.
- start_on_trigger=1, trig_addr=0x1000, packets at 0x0FF0, 0x1000, 0x1004 -> 0x0FF0 not forwarded or counted; 0x1000 and 0x1004 forwarded; state 1->2 after 0x1000.
- mode2 lo=0x2000 hi=0x20FF, packets 0x1FFC, 0x2000, 0x20FF, 0x2100 -> only 0x2000 and 0x20FF forwarded; drop_cnt=2. Same packets in mode3 -> the other two forwarded.
- post=3, mode0, 6 valid packets -> exactly 3 forwarded; post_cnt_remaining 3->2->1->0; state DONE after the 3rd; cfg_clear -> IDLE with counters 0.
- debug_en dropped mid-CAPTURE while packets are valid -> no strobe from that cycle; state IDLE next cycle; fwd_cnt holds. Restore debug_en -> capture restarts.
- Assert rst asynchronously mid-packet -> all outputs 0 immediately; state IDLE; no strobe after release until cfg_en re-enables.
